// File: rtl/seq_alu_pkg.sv
// Shared op-code and FSM state definitions for the sequential ALU.
// Holds the ALU_* op codes (including the iterative multiply/divide
// codes) and the controller state encodings used by seq_alu.
package seq_alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] ALU_NOP   = 5'd0;
  localparam logic [OP_W-1:0] ALU_ADDU  = 5'd1;
  localparam logic [OP_W-1:0] ALU_ADD   = 5'd2;
  localparam logic [OP_W-1:0] ALU_SUBU  = 5'd3;
  localparam logic [OP_W-1:0] ALU_SUB   = 5'd4;
  localparam logic [OP_W-1:0] ALU_AND   = 5'd5;
  localparam logic [OP_W-1:0] ALU_OR    = 5'd6;
  localparam logic [OP_W-1:0] ALU_NOR   = 5'd7;
  localparam logic [OP_W-1:0] ALU_XOR   = 5'd8;
  localparam logic [OP_W-1:0] ALU_SLT   = 5'd9;
  localparam logic [OP_W-1:0] ALU_SLTU  = 5'd10;
  localparam logic [OP_W-1:0] ALU_SLL   = 5'd11;
  localparam logic [OP_W-1:0] ALU_SRL   = 5'd12;
  localparam logic [OP_W-1:0] ALU_SRA   = 5'd13;
  localparam logic [OP_W-1:0] ALU_MULT  = 5'd14;
  localparam logic [OP_W-1:0] ALU_MULTU = 5'd15;
  localparam logic [OP_W-1:0] ALU_DIV   = 5'd16;
  localparam logic [OP_W-1:0] ALU_DIVU  = 5'd17;

  // Controller states: single-step ops skip CALC and go straight to DONE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // True for the ops that run on the iterative multiply/divide unit.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) ||
           (op == ALU_DIV)  || (op == ALU_DIVU);
  endfunction

  // True for the signed flavours of multiply/divide.
  function automatic logic is_signed_md(input logic [OP_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

  // True for the divide flavours.
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with signs fixed on the final step.
// Operands are captured on start; exactly WIDTH iterations follow, and
// done/hi/lo are presented combinationally during the last iteration so
// the controller can register them on that same edge.
module alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;     // product / quotient negative
  logic             neg_hi_q, neg_hi_d;     // remainder negative
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;       // original dividend for divide-by-zero
  logic [WIDTH-1:0] acc_q, acc_d;           // product upper half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;             // multiplier / dividend-quotient shift reg
  logic [WIDTH-1:0] opnd_q, opnd_d;         // multiplicand / divisor magnitude

  logic             signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] acc_step, lo_step;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;

  assign signed_op = is_signed_md(op);
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  assign done      = active_q && (cnt_q == LAST);

  // One iteration of either algorithm, computed from the current registers.
  // NOTE: every variable written in an always_comb gets a value on every path (defaults first) so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    acc_step  = mul_sum[WIDTH:1];
    lo_step   = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      acc_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
      lo_step  = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Final sign fix-up and divide-by-zero override, valid while done is high.
  always_comb begin
    prod_mag = {acc_step, lo_step};
    prod_fix = neg_lo_q ? -prod_mag : prod_mag;
    hi       = prod_fix[2*WIDTH-1:WIDTH];
    lo       = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        lo = '1;
        hi = a_raw_q;
      end else begin
        lo = neg_lo_q ? -lo_step : lo_step;
        hi = neg_hi_q ? -acc_step : acc_step;
      end
    end
  end

  // Next-state: load magnitudes on start, otherwise iterate while active.
  always_comb begin
    active_d   = active_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    a_raw_d    = a_raw_q;
    acc_d      = acc_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    if (start) begin
      active_d   = 1'b1;
      cnt_d      = '0;
      is_div_d   = is_div_op(op);
      neg_lo_d   = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_d   = signed_op && a[WIDTH-1];
      div_zero_d = (b == '0);
      a_raw_d    = a;
      acc_d      = '0;
      lo_d       = abs_a;
      opnd_d     = abs_b;
    end else if (active_q) begin
      acc_d = acc_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        active_d = 1'b0;
      end
    end
  end

  // Control registers: iteration counter and active flag.
  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  // Datapath registers.
  // NOTE: these carry no reset; they are always loaded on start before being read.
  always_ff @(posedge clk) begin
    is_div_q   <= is_div_d;
    neg_lo_q   <= neg_lo_d;
    neg_hi_q   <= neg_hi_d;
    div_zero_q <= div_zero_d;
    a_raw_q    <= a_raw_d;
    acc_q      <= acc_d;
    lo_q       <= lo_d;
    opnd_q     <= opnd_d;
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-step ops complete one cycle after acceptance,
// multiply/divide run WIDTH cycles on alu_muldiv. All results are held in
// output registers until the next operation's done cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] alu_src_a,
  input  logic [WIDTH-1:0] alu_src_b,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_hi,
  output logic             alu_zero,
  output logic             alu_ovf,
  output logic             alu_busy,
  output logic             alu_done
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             ovf_q, ovf_d;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum, diff;
  logic [WIDTH-1:0]   ss_result;
  logic               ss_ovf, ss_valid;
  logic               md_start, md_done;
  logic [WIDTH-1:0]   md_hi, md_lo;

  assign shamt    = alu_src_a[SHAMT_W-1:0];
  assign sum      = alu_src_a + alu_src_b;
  assign diff     = alu_src_a - alu_src_b;
  assign md_start = (state_q == ST_IDLE) && alu_start && is_muldiv(alu_op);

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (alu_op),
    .a     (alu_src_a),
    .b     (alu_src_b),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // Single-step result from the live inputs; registered on the accept edge,
  // which captures the operands. ss_valid is low for NOP/undefined codes.
  always_comb begin
    ss_result = result_q;
    ss_ovf    = 1'b0;
    ss_valid  = 1'b1;
    case (alu_op)
      ALU_ADDU: ss_result = sum;
      ALU_ADD: begin
        ss_result = sum;
        ss_ovf    = (alu_src_a[WIDTH-1] == alu_src_b[WIDTH-1]) &&
                    (sum[WIDTH-1] != alu_src_a[WIDTH-1]);
      end
      ALU_SUBU: ss_result = diff;
      ALU_SUB: begin
        ss_result = diff;
        ss_ovf    = (alu_src_a[WIDTH-1] != alu_src_b[WIDTH-1]) &&
                    (diff[WIDTH-1] != alu_src_a[WIDTH-1]);
      end
      ALU_AND:  ss_result = alu_src_a & alu_src_b;
      ALU_OR:   ss_result = alu_src_a | alu_src_b;
      ALU_NOR:  ss_result = ~(alu_src_a | alu_src_b);
      ALU_XOR:  ss_result = alu_src_a ^ alu_src_b;
      ALU_SLT:  ss_result = {{(WIDTH-1){1'b0}}, ($signed(alu_src_a) < $signed(alu_src_b))};
      ALU_SLTU: ss_result = {{(WIDTH-1){1'b0}}, (alu_src_a < alu_src_b)};
      ALU_SLL:  ss_result = alu_src_b << shamt;
      ALU_SRL:  ss_result = alu_src_b >> shamt;
      ALU_SRA:  ss_result = $unsigned($signed(alu_src_b) >>> shamt);
      default:  ss_valid  = 1'b0;
    endcase
  end

  // Controller next-state and output-register updates.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (alu_start) begin
          if (is_muldiv(alu_op)) begin
            state_d = ST_CALC;
          end else begin
            state_d = ST_DONE;
            if (ss_valid) begin
              result_d = ss_result;
              hi_d     = '0;
              ovf_d    = ss_ovf;
            end
          end
        end
      end
      ST_CALC: begin
        if (md_done) begin
          state_d  = ST_DONE;
          result_d = md_lo;
          hi_d     = md_hi;
          ovf_d    = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset clears results asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      ovf_q    <= ovf_d;
    end
  end

  assign alu_result = result_q;
  assign alu_hi     = hi_q;
  assign alu_ovf    = ovf_q;
  assign alu_zero   = (result_q == '0);
  assign alu_busy   = (state_q == ST_CALC);
  assign alu_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32 and WIDTH=8 instances).
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic [31:0] res, hi;
  logic        zero, ovf, busy, done;

  logic        start8;
  logic [4:0]  op8;
  logic [7:0]  a8, b8;
  logic [7:0]  res8, hi8;
  logic        zero8, ovf8, busy8, done8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .alu_start(start), .alu_op(op),
    .alu_src_a(a), .alu_src_b(b), .alu_result(res), .alu_hi(hi),
    .alu_zero(zero), .alu_ovf(ovf), .alu_busy(busy), .alu_done(done)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .alu_start(start8), .alu_op(op8),
    .alu_src_a(a8), .alu_src_b(b8), .alu_result(res8), .alu_hi(hi8),
    .alu_zero(zero8), .alu_ovf(ovf8), .alu_busy(busy8), .alu_done(done8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request for a single cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for alu_done with a cycle budget; lat counts cycles since the accept cycle.
  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat = lat0;
    busy_n = 0;
    while (!done && lat < 100) begin
      busy_n += int'(busy);
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] x,
                     input logic [31:0] y, input int exp_lat, input logic [31:0] exp_res,
                     input logic [31:0] exp_hi, input logic exp_ovf);
    int lat, busy_n;
    issue(o, x, y);
    wait_done(1, lat, busy_n);
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_res"},  64'(res), 64'(exp_res));
    check({tag, "_hi"},   64'(hi),  64'(exp_hi));
    check({tag, "_ovf"},  64'(ovf), 64'(exp_ovf));
    check({tag, "_zero"}, 64'(zero), 64'(exp_res == 32'd0));
    check({tag, "_busy"}, 64'(busy_n), 64'(exp_lat - 1));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, busy_n, dones;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_res",  64'(res),  64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_ovf",  64'(ovf),  64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Single-step ops.
    run("add_ovf",   ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 1, 32'h80000000, 32'h0, 1'b1);
    run("nop",       ALU_NOP,  32'h00000001, 32'h00000002, 1, 32'h80000000, 32'h0, 1'b1);
    run("undef",     5'd31,    32'h00000003, 32'h00000004, 1, 32'h80000000, 32'h0, 1'b1);
    run("sub_ovf",   ALU_SUB,  32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 32'h0, 1'b1);
    run("addu_wrap", ALU_ADDU, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 32'h0, 1'b0);
    run("subu",      ALU_SUBU, 32'h80000000, 32'h00000001, 1, 32'h7FFFFFFF, 32'h0, 1'b0);
    run("xor",       ALU_XOR,  32'hF0F0F0F0, 32'hFFFF0000, 1, 32'h0F0FF0F0, 32'h0, 1'b0);
    run("nor",       ALU_NOR,  32'h0F0F0000, 32'h000000FF, 1, 32'hF0F0FF00, 32'h0, 1'b0);
    run("or",        ALU_OR,   32'h0F0F0000, 32'h000000FF, 1, 32'h0F0F00FF, 32'h0, 1'b0);
    run("slt",       ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 1, 32'h00000001, 32'h0, 1'b0);
    run("sltu",      ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 1, 32'h00000000, 32'h0, 1'b0);
    run("sll",       ALU_SLL,  32'h00000024, 32'h00000001, 1, 32'h00000010, 32'h0, 1'b0);
    run("srl",       ALU_SRL,  32'h00000004, 32'h80000000, 1, 32'h08000000, 32'h0, 1'b0);
    run("sra4",      ALU_SRA,  32'h00000024, 32'h80000000, 1, 32'hF8000000, 32'h0, 1'b0);
    run("sra_upper", ALU_SRA,  32'h00000104, 32'h80000000, 1, 32'hF8000000, 32'h0, 1'b0);
    run("add_ovf2",  ALU_ADD,  32'h40000000, 32'h40000000, 1, 32'h80000000, 32'h0, 1'b1);

    // Multiply / divide.
    run("mult",       ALU_MULT,  32'hFFFFFFFD, 32'h00000007, 33, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
    run("multu",      ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    run("div",        ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run("div_neg_b",  ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'h00000001, 1'b0);
    run("divu_zero",  ALU_DIVU,  32'h00000005, 32'h00000000, 33, 32'hFFFFFFFF, 32'h00000005, 1'b0);
    run("div_zero",   ALU_DIV,   32'hFFFFFFF8, 32'h00000000, 33, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b0);
    run("div_minneg", ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'h00000000, 1'b0);
    run("divu",       ALU_DIVU,  32'h00000064, 32'h00000007, 33, 32'h0000000E, 32'h00000002, 1'b0);
    run("and_hi0",    ALU_AND,   32'hFF00FF00, 32'h0FF00FF0, 1,  32'h0F000F00, 32'h00000000, 1'b0);

    // A start pulse during CALC is ignored and not queued.
    issue(ALU_MULTU, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    op = ALU_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, lat, busy_n);
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_res", 64'(res), 64'd42);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("ign_no_extra_done", 64'(dones), 64'd0);

    // Reset in CALC cycle 10 aborts the operation.
    issue(ALU_MULTU, 32'd123, 32'd456);
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_res",  64'(res),  64'd0);
    check("abort_hi",   64'(hi),   64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    check("abort_ovf",  64'(ovf),  64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      dones += int'(done);
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_res_hold", 64'(res), 64'd0);
    run("xor_after_rst", ALU_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 1, 32'h0F0FF0F0, 32'h0, 1'b0);

    // alu_start held high through a DIVU with inputs changed during CALC.
    @(negedge clk);
    op = ALU_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    a = 32'd50; b = 32'd5;
    wait_done(1, lat, busy_n);
    check("hold_lat", 64'(lat), 64'd33);
    check("hold_res", 64'(res), 64'h0E);
    check("hold_hi",  64'(hi),  64'h02);
    @(negedge clk);
    check("hold_idle_done", 64'(done), 64'd0);
    check("hold_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("hold_reaccept", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(1, lat, busy_n);
    check("hold2_lat", 64'(lat), 64'd33);
    check("hold2_res", 64'(res), 64'h0A);
    check("hold2_hi",  64'(hi),  64'h00);
    @(negedge clk);
    check("hold2_pulse", 64'(done), 64'd0);

    // WIDTH=8 multiply: -3 * 7.
    @(negedge clk);
    op8 = ALU_MULT; a8 = 8'hFD; b8 = 8'h07; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("w8_lat", 64'(lat), 64'd9);
    check("w8_res", 64'(res8), 64'hEB);
    check("w8_hi",  64'(hi8),  64'hFF);
    check("w8_ovf", 64'(ovf8), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
